// File: rtl/counter_param.sv
// -----------------------------------------------------------------------------
// counter_param
//   Parametrised WIDTH-bit up/down counter with a per-cycle step, wrap or
//   saturate mode, a compare match and one-cycle overflow/underflow pulses.
//   It is the base for the program counter (STEP=4, up, wrap) and for the
//   control-unit cycle and loop counters.
//
//   Optional build macro: COUNTER_STICKY_EN
//     When defined, adds clr_sticky / err_sticky. err_sticky is set the cycle
//     after any ovf/unf pulse and holds until clr_sticky or reset. A set and a
//     clear in the same cycle resolve to set.
//
// Parameters
//   WIDTH     counter, load and compare width (>= 2)
//   STEP_W    width of the unsigned step input (1..WIDTH)
//   RESET_VAL value of count after reset
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   en         in   count enable, one step per cycle
//   load       in   synchronous load of load_val (beats en)
//   load_val   in   WIDTH  value written on load
//   up         in   1 = add step, 0 = subtract step
//   sat        in   1 = saturate at limits, 0 = wrap modulo 2^WIDTH
//   step       in   STEP_W unsigned step magnitude
//   cmp_val    in   WIDTH  compare value
//   clr_sticky in   clear err_sticky          (COUNTER_STICKY_EN only)
//   count      out  WIDTH  registered count
//   ovf        out  registered one-cycle pulse, up-count passed all ones
//   unf        out  registered one-cycle pulse, down-count passed zero
//   match      out  combinational count == cmp_val
//   at_max     out  combinational count == all ones
//   at_min     out  combinational count == 0
//   err_sticky out  sticky ovf/unf record     (COUNTER_STICKY_EN only)
// -----------------------------------------------------------------------------
module counter_param #(
  parameter int              WIDTH     = 8,
  parameter int              STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              up,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  cmp_val,
`ifdef COUNTER_STICKY_EN
  input  logic              clr_sticky,
  output logic              err_sticky,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              ovf,
  output logic              unf,
  output logic              match,
  output logic              at_max,
  output logic              at_min
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Zero-extend the step to the WIDTH+1 arithmetic width so the top bit of
  // the sum/difference is the carry/borrow.
  function automatic logic [WIDTH:0] ext_step(input logic [STEP_W-1:0] s);
    return {{(WIDTH + 1 - STEP_W){1'b0}}, s};
  endfunction

  // Apply the limit policy: on carry/borrow either clamp or keep the
  // modulo result.
  function automatic logic [WIDTH-1:0] limit(input logic [WIDTH:0]   raw,
                                             input logic             do_sat,
                                             input logic [WIDTH-1:0] clamp);
    if (raw[WIDTH] && do_sat) return clamp;
    return raw[WIDTH-1:0];
  endfunction

  logic [WIDTH:0] sum_up;
  logic [WIDTH:0] sum_dn;

  always_comb begin
    sum_up  = {1'b0, count_q} + ext_step(step);
    sum_dn  = {1'b0, count_q} - ext_step(step);
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (up) begin
        // Already at all ones with sat=1 and step!=0 still carries, so the
        // count clamps in place and ovf keeps pulsing.
        count_d = limit(sum_up, sat, {WIDTH{1'b1}});
        ovf_d   = sum_up[WIDTH];
      end else begin
        count_d = limit(sum_dn, sat, {WIDTH{1'b0}});
        unf_d   = sum_dn[WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef COUNTER_STICKY_EN
  logic err_q, err_d;

  // Set from the registered pulses, so err follows one cycle after ovf/unf.
  always_comb begin
    err_d = err_q;
    if (ovf_q || unf_q) begin
      err_d = 1'b1;
    end else if (clr_sticky) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;
`endif

  assign count  = count_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign match  = (count_q == cmp_val);
  assign at_max = (count_q == {WIDTH{1'b1}});
  assign at_min = (count_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param (WIDTH=8, STEP_W=4, RESET_VAL=8'h10).
// Stimulus drives one cycle per call and queues the hand-computed result of
// that edge; a monitor pops one entry at each falling edge and compares.
module tb_counter_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       up = 1'b1;
  logic       sat = 1'b0;
  logic [3:0] step = 4'h0;
  logic [7:0] cmp_val = 8'h00;
  logic [7:0] count;
  logic       ovf, unf, match, at_max, at_min;
`ifdef COUNTER_STICKY_EN
  logic       clr_sticky = 1'b0;
  logic       err_sticky;
`endif

  always #5 clk = ~clk;

  counter_param #(
    .WIDTH    (8),
    .STEP_W   (4),
    .RESET_VAL(8'h10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .up        (up),
    .sat       (sat),
    .step      (step),
    .cmp_val   (cmp_val),
`ifdef COUNTER_STICKY_EN
    .clr_sticky(clr_sticky),
    .err_sticky(err_sticky),
`endif
    .count     (count),
    .ovf       (ovf),
    .unf       (unf),
    .match     (match),
    .at_max    (at_max),
    .at_min    (at_min)
  );

  typedef struct {
    int         idx;
    logic [7:0] cnt;
    logic       ovf;
    logic       unf;
    logic [7:0] cmp;
    logic       rst_n;
    logic       clr;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_vec = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, req);
    end
  endtask

  // One cycle: drive inputs after the falling edge, queue the expected
  // post-edge result.
  task automatic cyc(input logic r, input logic ld, input logic [7:0] lv,
                     input logic e, input logic u, input logic s,
                     input logic [3:0] st, input logic [7:0] cmp,
                     input logic c, input logic [7:0] ec,
                     input logic eo, input logic eu);
    exp_t x;
    @(negedge clk);
    #1;
    rst_n = r; load = ld; load_val = lv; en = e; up = u; sat = s;
    step = st; cmp_val = cmp;
`ifdef COUNTER_STICKY_EN
    clr_sticky = c;
`endif
    x.idx = n_vec; x.cnt = ec; x.ovf = eo; x.unf = eu; x.cmp = cmp;
    x.rst_n = r; x.clr = c;
    exp_q.push_back(x);
    n_vec++;
  endtask

  task automatic monitor_loop();
    exp_t e;
    logic m_err = 1'b0;
    logic p_ovf = 1'b0;
    logic p_unf = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",  e.idx, {24'h0, count}, {24'h0, e.cnt});
        chk("ovf",    e.idx, {31'h0, ovf},   {31'h0, e.ovf});
        chk("unf",    e.idx, {31'h0, unf},   {31'h0, e.unf});
        chk("match",  e.idx, {31'h0, match}, {31'h0, (e.cnt == e.cmp)});
        chk("at_max", e.idx, {31'h0, at_max}, {31'h0, (e.cnt == 8'hFF)});
        chk("at_min", e.idx, {31'h0, at_min}, {31'h0, (e.cnt == 8'h00)});
        if (!e.rst_n)          m_err = 1'b0;
        else if (p_ovf | p_unf) m_err = 1'b1;
        else if (e.clr)        m_err = 1'b0;
        p_ovf = e.ovf;
        p_unf = e.unf;
`ifdef COUNTER_STICKY_EN
        chk("err_sticky", e.idx, {31'h0, err_sticky}, {31'h0, m_err});
`endif
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    //   rst ld  lv     en up sat st    cmp    clr cnt    ovf unf
    // reset held for two edges, simultaneous load/en ignored
    cyc(0, 0, 8'h00, 0, 1, 0, 4'd0, 8'h00, 0, 8'h10, 0, 0);
    cyc(0, 1, 8'hAA, 1, 1, 0, 4'd3, 8'h00, 0, 8'h10, 0, 0);
    // load beats en, no step applied
    cyc(1, 1, 8'hF0, 1, 1, 0, 4'd3, 8'h00, 0, 8'hF0, 0, 0);
    // wrap up: FE + 3 -> 01 with ovf, then hold clears ovf
    cyc(1, 1, 8'hFE, 0, 1, 0, 4'd0, 8'h00, 0, 8'hFE, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd3, 8'h00, 0, 8'h01, 1, 0);
    cyc(1, 0, 8'h00, 0, 1, 0, 4'd3, 8'h00, 0, 8'h01, 0, 0);
    // saturate down: 02 - 5 -> 00, unf on both cycles
    cyc(1, 1, 8'h02, 0, 0, 1, 4'd0, 8'h00, 0, 8'h02, 0, 0);
    cyc(1, 0, 8'h00, 1, 0, 1, 4'd5, 8'h00, 0, 8'h00, 0, 1);
    cyc(1, 0, 8'h00, 1, 0, 1, 4'd5, 8'h00, 0, 8'h00, 0, 1);
    // exact landing on zero is not underflow
    cyc(1, 1, 8'h05, 0, 0, 1, 4'd0, 8'h00, 0, 8'h05, 0, 0);
    cyc(1, 0, 8'h00, 1, 0, 1, 4'd5, 8'h00, 0, 8'h00, 0, 0);
    // compare: count 04..08, match only at 07
    cyc(1, 1, 8'h04, 0, 1, 0, 4'd0, 8'h07, 0, 8'h04, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h05, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h06, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h07, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h08, 0, 0);
    // limits: at_max, saturating at all ones still pulses ovf
    cyc(1, 1, 8'hFF, 0, 1, 1, 4'd0, 8'h07, 0, 8'hFF, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 1, 4'd2, 8'h07, 0, 8'hFF, 1, 0);
    cyc(1, 0, 8'h00, 1, 1, 1, 4'd2, 8'h07, 0, 8'hFF, 1, 0);
    // step 0 with en: hold, no flags
    cyc(1, 0, 8'h00, 1, 1, 1, 4'd0, 8'h07, 0, 8'hFF, 0, 0);
    // wrap up by 1 to 00, then wrap down by 1 back to FF
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h00, 1, 0);
    cyc(1, 0, 8'h00, 1, 0, 0, 4'd1, 8'h07, 0, 8'hFF, 0, 1);
    // exact landing on all ones is not overflow
    cyc(1, 1, 8'hFC, 0, 1, 0, 4'd0, 8'h07, 0, 8'hFC, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd3, 8'h07, 0, 8'hFF, 0, 0);
    // plain down count without borrow
    cyc(1, 1, 8'h20, 0, 0, 0, 4'd0, 8'h07, 0, 8'h20, 0, 0);
    cyc(1, 0, 8'h00, 1, 0, 0, 4'd15, 8'h07, 0, 8'h11, 0, 0);
    // reset beats load and en on the same edge
    cyc(0, 1, 8'h55, 1, 1, 0, 4'd1, 8'h07, 0, 8'h10, 0, 0);
    // reset mid-count from 40, then resume from RESET_VAL
    cyc(1, 1, 8'h40, 0, 1, 0, 4'd0, 8'h07, 0, 8'h40, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h41, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h42, 0, 0);
    cyc(0, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h10, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h11, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd1, 8'h07, 0, 8'h12, 0, 0);

`ifdef COUNTER_STICKY_EN
    // sticky set after ovf, held across idle, cleared, then set beats clear
    cyc(1, 1, 8'hFE, 0, 1, 0, 4'd0, 8'h07, 0, 8'hFE, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd3, 8'h07, 0, 8'h01, 1, 0);
    for (int i = 0; i < 11; i++)
      cyc(1, 0, 8'h00, 0, 1, 0, 4'd0, 8'h07, 0, 8'h01, 0, 0);
    cyc(1, 0, 8'h00, 0, 1, 0, 4'd0, 8'h07, 1, 8'h01, 0, 0);
    cyc(1, 0, 8'h00, 0, 1, 0, 4'd0, 8'h07, 0, 8'h01, 0, 0);
    cyc(1, 1, 8'hFE, 0, 1, 0, 4'd0, 8'h07, 0, 8'hFE, 0, 0);
    cyc(1, 0, 8'h00, 1, 1, 0, 4'd3, 8'h07, 0, 8'h01, 1, 0);
    cyc(1, 0, 8'h00, 0, 1, 0, 4'd0, 8'h07, 1, 8'h01, 0, 0);
    cyc(1, 0, 8'h00, 0, 1, 0, 4'd0, 8'h07, 0, 8'h01, 0, 0);
`endif

    // bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", n_vec, exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
- Parametrised successor to the 4-bit loadable counter: WIDTH-bit up/down counter with per-cycle step, wrap or saturate mode, compare match and overflow/underflow event flags.
- Serves as the base for the CPU's program counter (STEP=4, up, wrap) and for control-unit cycle/loop counters.
- All state updates occur on the rising clk edge.

Parameters:
- WIDTH, 8, counter and load/compare width in bits (≥2).
- STEP_W, 4, width of the step input in bits (1..WIDTH).
- RESET_VAL, 0, value of count after reset (WIDTH bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  count enable; one step per cycle while high.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value written on load.
- up  input  1  direction: 1 = add step, 0 = subtract step.
- sat  input  1  mode: 1 = saturate at limits, 0 = wrap modulo 2^WIDTH.
- step  input  STEP_W  increment/decrement magnitude, unsigned.
- cmp_val  input  WIDTH  compare value.
- count  output  WIDTH  registered counter value.
- ovf  output  1  registered one-cycle pulse: up-count crossed 2^WIDTH-1.
- unf  output  1  registered one-cycle pulse: down-count crossed 0.
- match  output  1  combinational: count == cmp_val.
- at_max  output  1  combinational: count == all ones.
- at_min  output  1  combinational: count == 0.

Behaviour:
- Priority per edge: rst_n low > load > en > hold.
- Reset (rst_n=0 at edge): count=RESET_VAL, ovf=0, unf=0. Takes effect from any state, including mid-count or a simultaneous load.
- Load: count=load_val next cycle; ovf=unf=0; en, up, sat and step are ignored that cycle.
- Count, en=1 and load=0: compute sum = {1'b0,count} ± zero-extended step in WIDTH+1 bits.
  - Up, no carry: count=sum[WIDTH-1:0], ovf=0.
  - Up, carry and sat=0: count=sum[WIDTH-1:0] (wrap), ovf=1 for one cycle.
  - Up, carry and sat=1: count=all ones, ovf=1 for one cycle. If count is already all ones and step≠0, count holds and ovf pulses again every enabled cycle.
  - Down, borrow and sat=0: count wraps modulo 2^WIDTH, unf=1.
  - Down, borrow and sat=1: count=0, unf=1. Repeats while at 0 with step≠0.
  - Exact landing on all ones (up) or on 0 (down) is not an overflow or underflow. Flags stay 0.
- step=0 with en=1: count holds, ovf=unf=0.
- Hold (en=0, load=0): count holds, ovf=unf=0. Flags are never sticky in the base build.
- Latency: count, ovf and unf reflect inputs sampled at edge N from after edge N (one cycle). match, at_max and at_min follow count combinationally, with zero added latency.
- up and sat may change every cycle. Only the values sampled at the edge matter.
- No X on outputs after the first reset edge. Before the first reset, count is undefined.

Optional Feature:
- Macro: COUNTER_STICKY_EN.
- Defined:
  - Adds input clr_sticky (1 bit) and output err_sticky (1 bit).
  - err_sticky is set the cycle after any ovf or unf pulse, and holds until clr_sticky=1 or reset.
  - If set and clear occur in the same cycle, set wins.
  - Reset value is 0.
- Undefined: neither port exists. Behaviour is otherwise identical.

Test Plan:
- Reset/load: WIDTH=8, RESET_VAL=8'h10, hold rst_n=0 for 2 edges -> count=8'h10, ovf=unf=0. Then load=1, load_val=8'hF0 for 1 cycle with en=1 -> count=8'hF0 next cycle, no step applied.
- Wrap up: count=8'hFE, up=1, sat=0, step=3, en=1 for one edge -> count=8'h01, ovf=1 for exactly one cycle. Next edge with en=0 -> count=8'h01, ovf=0.
- Saturate down: count=8'h02, up=0, sat=1, step=5, en=1 for 2 edges -> count=8'h00 after edge 1 and stays 8'h00, unf=1 on both cycles. Exact landing check: count=8'h05, step=5 -> count=8'h00, unf=0, at_min=1.
- Compare/limits: cmp_val=8'h07, count from 8'h04 up by step=1 -> match=1 only while count=8'h07. at_max=1 at 8'hFF, at_min=1 at 8'h00. step=0 with en=1 -> count unchanged, no flags.
- Priority: rst_n=0, load=1, en=1 on the same edge -> count=RESET_VAL. Reset asserted mid-sequence while counting from 8'h40 -> count=RESET_VAL at the next edge, counting resumes from RESET_VAL after release.
- COUNTER_STICKY_EN: trigger ovf -> err_sticky=1 the following cycle and held across 10 idle cycles. clr_sticky=1 -> err_sticky=0. Simultaneous ovf pulse and clr_sticky -> err_sticky stays 1.
